// File: rtl/bp_pkg.sv
// Shared types and sizes for the branch predictor table write controller.
package bp_pkg;

  localparam int unsigned BP_IDX_W     = 10;
  localparam int unsigned BP_PHT_IDX_W = 8;
  localparam int unsigned BP_DEPTH     = 4;
  localparam int unsigned TAG_W        = 30 - BP_IDX_W;
  localparam logic [1:0]  PHT_RESET    = 2'b00;

  typedef enum logic {CLEAR, RUN} bp_state_e;

  // Resolved-branch update as captured from EX
  typedef struct packed {
    logic [31:0]             pc;
    logic [31:0]             target;
    logic                    taken;
    logic [BP_PHT_IDX_W-1:0] pattern;
  } bp_upd_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [29:0]      target;
  } bp_btb_entry_t;

endpackage

// File: rtl/bp_table_ctrl_if.sv
// EX update channel, control inputs and table write port of bp_table_ctrl.
interface bp_table_ctrl_if #(
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned PHT_IDX_W = 8
);
  localparam int unsigned WD_W = 1 + (30 - IDX_W) + 30;

  logic                 i_flush_req;
  logic                 i_tbl_wr_block;
  logic                 i_upd_valid;
  logic [31:0]          i_upd_pc;
  logic [31:0]          i_upd_target;
  logic                 i_upd_taken;
  logic [PHT_IDX_W-1:0] i_upd_pattern;
  logic                 o_upd_ready;
  logic                 o_busy;
  logic                 o_btb_we;
  logic [IDX_W-1:0]     o_btb_idx;
  logic [WD_W-1:0]      o_btb_wdata;
  logic                 o_pht_we;
  logic                 o_pht_clr;
  logic [PHT_IDX_W-1:0] o_pht_idx;
  logic                 o_pht_taken;

  modport slave (
    input  i_flush_req, i_tbl_wr_block, i_upd_valid, i_upd_pc, i_upd_target,
           i_upd_taken, i_upd_pattern,
    output o_upd_ready, o_busy, o_btb_we, o_btb_idx, o_btb_wdata, o_pht_we,
           o_pht_clr, o_pht_idx, o_pht_taken
  );

  modport master (
    output i_flush_req, i_tbl_wr_block, i_upd_valid, i_upd_pc, i_upd_target,
           i_upd_taken, i_upd_pattern,
    input  o_upd_ready, o_busy, o_btb_we, o_btb_idx, o_btb_wdata, o_pht_we,
           o_pht_clr, o_pht_idx, o_pht_taken
  );
endinterface

// File: rtl/bp_upd_fifo.sv
// Small in-order FIFO of resolved-branch updates with synchronous clear.
module bp_upd_fifo
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH = BP_DEPTH
) (
  input  logic    i_clk,
  input  logic    i_clr,
  input  logic    i_push,
  input  bp_upd_t i_data,
  input  logic    i_pop,
  output bp_upd_t o_head,
  output logic    o_full,
  output logic    o_empty
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  bp_upd_t          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  always_ff @(posedge i_clk) begin
    if (i_push) mem[wr_ptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (i_push) wr_ptr <= wr_ptr + 1'b1;
      if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign o_head  = mem[rd_ptr];
  assign o_full  = (count == (PTR_W+1)'(DEPTH));
  assign o_empty = (count == '0);

endmodule

// File: rtl/bp_table_ctrl.sv
// Branch predictor table write controller: post-reset/flush clear sweep plus queued EX updates.
// Optional BP_TBL_PERF_CNT_EN adds committed-write and update-stall counters.
module bp_table_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W     = BP_IDX_W,
  parameter int unsigned PHT_IDX_W = BP_PHT_IDX_W,
  parameter int unsigned DEPTH     = BP_DEPTH
) (
  input  logic           i_clk,
  input  logic           i_rst,
  bp_table_ctrl_if.slave bus
`ifdef BP_TBL_PERF_CNT_EN
  ,
  output logic [31:0]    o_wr_cnt,
  output logic [31:0]    o_stall_cnt
`endif
);
  bp_state_e        state;
  logic [IDX_W-1:0] cnt;
  bp_upd_t          upd_in;
  bp_upd_t          head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             unused_bits;

  always_comb begin
    upd_in         = '0;
    upd_in.pc      = bus.i_upd_pc;
    upd_in.target  = bus.i_upd_target;
    upd_in.taken   = bus.i_upd_taken;
    upd_in.pattern = BP_PHT_IDX_W'(bus.i_upd_pattern);
  end

  // Updates accepted while clearing are dropped rather than stalling EX
  assign push = !i_rst && !bus.i_flush_req && (state == RUN) &&
                bus.i_upd_valid && bus.o_upd_ready;

  bp_upd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_clr   (i_rst || bus.i_flush_req),
    .i_push  (push),
    .i_data  (upd_in),
    .i_pop   (pop),
    .o_head  (head),
    .o_full  (full),
    .o_empty (empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.i_flush_req) begin
      state <= CLEAR;
      cnt   <= '0;
    end else if (state == CLEAR && !bus.i_tbl_wr_block) begin
      cnt <= cnt + 1'b1;
      if (cnt == '1) state <= RUN;
    end
  end

  // Single write port: clear sweep in CLEAR, FIFO head in RUN, nothing when blocked
  always_comb begin
    bus.o_busy      = i_rst || (state == CLEAR);
    bus.o_upd_ready = !i_rst && ((state == CLEAR) || !full);
    bus.o_btb_we    = 1'b0;
    bus.o_btb_idx   = '0;
    bus.o_btb_wdata = '0;
    bus.o_pht_we    = 1'b0;
    bus.o_pht_clr   = 1'b0;
    bus.o_pht_idx   = '0;
    bus.o_pht_taken = 1'b0;
    pop             = 1'b0;
    if (!i_rst && !bus.i_flush_req && !bus.i_tbl_wr_block) begin
      if (state == CLEAR) begin
        bus.o_btb_we  = 1'b1;
        bus.o_btb_idx = cnt;
        if ((cnt >> PHT_IDX_W) == '0) begin
          bus.o_pht_clr = 1'b1;
          bus.o_pht_idx = cnt[PHT_IDX_W-1:0];
        end
      end else if (!empty) begin
        pop             = 1'b1;
        bus.o_btb_we    = 1'b1;
        bus.o_btb_idx   = head.pc[IDX_W+1:2];
        bus.o_btb_wdata = {1'b1, head.pc[31:IDX_W+2], head.target[31:2]};
        bus.o_pht_we    = 1'b1;
        bus.o_pht_idx   = PHT_IDX_W'(head.pattern);
        bus.o_pht_taken = head.taken;
      end
    end
  end

  assign unused_bits = &{1'b0, head.pc[1:0], head.target[1:0]};

`ifdef BP_TBL_PERF_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_wr_cnt    <= '0;
      o_stall_cnt <= '0;
    end else begin
      if (pop) o_wr_cnt <= o_wr_cnt + 32'd1;
      if (bus.i_upd_valid && !bus.o_upd_ready) o_stall_cnt <= o_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: per-cycle expectations from a queue-based reference model.
module tb_bp_table_ctrl;
  import bp_pkg::*;

  localparam int unsigned IDX_W     = 10;
  localparam int unsigned PHT_IDX_W = 8;
  localparam int unsigned DEPTH     = 4;
  localparam int          NSWEEP    = 1024;
  localparam int          NPHT      = 256;

  typedef struct {
    logic        busy;
    logic        ready;
    logic        btb_we;
    logic [9:0]  btb_idx;
    logic [50:0] wdata;
    logic        pht_we;
    logic        pht_clr;
    logic [7:0]  pht_idx;
    logic        pht_taken;
    logic        perf_chk;
    logic [31:0] wr_cnt;
    logic [31:0] stall_cnt;
  } exp_t;

  logic i_clk;
  logic i_rst;

  bp_table_ctrl_if #(.IDX_W(IDX_W), .PHT_IDX_W(PHT_IDX_W)) bus ();

`ifdef BP_TBL_PERF_CNT_EN
  logic [31:0] wr_cnt;
  logic [31:0] stall_cnt;
`endif

  bp_table_ctrl #(.IDX_W(IDX_W), .PHT_IDX_W(PHT_IDX_W), .DEPTH(DEPTH)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
`ifdef BP_TBL_PERF_CNT_EN
    ,
    .o_wr_cnt    (wr_cnt),
    .o_stall_cnt (stall_cnt)
`endif
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // Reference model state: sweep position (NSWEEP = done) and pending update queue
  int          clear_pos;
  bp_upd_t     mq[$];
  exp_t        exp_q[$];
  logic [31:0] exp_wr;
  logic [31:0] exp_stall;
  bit          last_acc;
  int          n_chk;
  int          n_fail;
  int          cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: one expectation record per cycle, compared mid-cycle
  initial begin
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy",    64'(bus.o_busy),      64'(e.busy));
        chk("ready",   64'(bus.o_upd_ready), 64'(e.ready));
        chk("btb_we",  64'(bus.o_btb_we),    64'(e.btb_we));
        chk("pht_we",  64'(bus.o_pht_we),    64'(e.pht_we));
        chk("pht_clr", 64'(bus.o_pht_clr),   64'(e.pht_clr));
        if (e.btb_we) begin
          chk("btb_idx",   64'(bus.o_btb_idx),   64'(e.btb_idx));
          chk("btb_wdata", 64'(bus.o_btb_wdata), 64'(e.wdata));
        end
        if (e.pht_we || e.pht_clr) chk("pht_idx", 64'(bus.o_pht_idx), 64'(e.pht_idx));
        if (e.pht_we) chk("pht_taken", 64'(bus.o_pht_taken), 64'(e.pht_taken));
`ifdef BP_TBL_PERF_CNT_EN
        if (e.perf_chk) begin
          chk("wr_cnt",    64'(wr_cnt),    64'(e.wr_cnt));
          chk("stall_cnt", 64'(stall_cnt), 64'(e.stall_cnt));
        end
`endif
      end
      cyc++;
    end
  end

  // Compute this cycle's expected outputs from the driven inputs, advance model, clock
  task automatic step();
    exp_t    e;
    bp_upd_t u;
    bit      in_clr;
    e = '{default: '0};
    last_acc = 1'b0;
    if (i_rst) begin
      e.busy = 1'b1;
      clear_pos = 0;
      mq.delete();
      exp_wr = '0;
      exp_stall = '0;
    end else begin
      in_clr     = (clear_pos < NSWEEP);
      e.busy     = in_clr;
      e.ready    = in_clr || (mq.size() < DEPTH);
      e.perf_chk = 1'b1;
      e.wr_cnt   = exp_wr;
      e.stall_cnt = exp_stall;
      last_acc   = bus.i_upd_valid && e.ready;
      if (bus.i_upd_valid && !e.ready) exp_stall = exp_stall + 32'd1;
      if (bus.i_flush_req) begin
        clear_pos = 0;
        mq.delete();
        in_clr = 1'b1;
      end else if (!bus.i_tbl_wr_block) begin
        if (in_clr) begin
          e.btb_we  = 1'b1;
          e.btb_idx = clear_pos[9:0];
          if (clear_pos < NPHT) begin
            e.pht_clr = 1'b1;
            e.pht_idx = clear_pos[7:0];
          end
          clear_pos++;
        end else if (mq.size() > 0) begin
          u = mq.pop_front();
          e.btb_we    = 1'b1;
          e.btb_idx   = u.pc[11:2];
          e.wdata     = {1'b1, u.pc[31:12], u.target[31:2]};
          e.pht_we    = 1'b1;
          e.pht_idx   = u.pattern;
          e.pht_taken = u.taken;
          exp_wr = exp_wr + 32'd1;
        end
      end
      if (last_acc && !in_clr)
        mq.push_back('{pc: bus.i_upd_pc, target: bus.i_upd_target,
                       taken: bus.i_upd_taken, pattern: bus.i_upd_pattern});
    end
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic [7:0] pat);
    bus.i_upd_valid   = 1'b1;
    bus.i_upd_pc      = pc;
    bus.i_upd_target  = tgt;
    bus.i_upd_taken   = tk;
    bus.i_upd_pattern = pat;
  endtask

  task automatic rand_upd();
    set_upd($urandom, $urandom, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    clear_pos = 0;
    exp_wr = '0;
    exp_stall = '0;
    i_rst = 1'b1;
    bus.i_flush_req = 1'b0;
    bus.i_tbl_wr_block = 1'b0;
    set_upd('0, '0, 1'b0, '0);
    bus.i_upd_valid = 1'b0;
    @(posedge i_clk);
    #1;
    run(3);
    i_rst = 1'b0;
    run(NSWEEP + 6);

    // Known update right after the sweep
    set_upd(32'h0000_1008, 32'h0000_2000, 1'b1, 8'h5A);
    step();
    bus.i_upd_valid = 1'b0;
    run(3);

    // Fill under block, fifth held off until the queue drains
    bus.i_tbl_wr_block = 1'b1;
    for (int i = 0; i < 4; i++) begin rand_upd(); step(); end
    rand_upd();
    run(3);
    bus.i_tbl_wr_block = 1'b0;
    for (int g = 0; g < 20 && !last_acc; g++) step();
    bus.i_upd_valid = 1'b0;
    run(6);

    // Flush with queued entries
    bus.i_tbl_wr_block = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_upd(); step(); end
    bus.i_upd_valid = 1'b0;
    bus.i_flush_req = 1'b1;
    step();
    bus.i_flush_req = 1'b0;
    bus.i_tbl_wr_block = 1'b0;
    for (int i = 0; i < 20; i++) begin rand_upd(); step(); end
    bus.i_upd_valid = 1'b0;
    run(NSWEEP);

    // Reset mid-sweep, then a sweep with the port blocked every other cycle
    bus.i_flush_req = 1'b1;
    step();
    bus.i_flush_req = 1'b0;
    run(500);
    i_rst = 1'b1;
    run(2);
    i_rst = 1'b0;
    for (int i = 0; i < 2 * NSWEEP + 8; i++) begin
      bus.i_tbl_wr_block = 1'(i % 2);
      step();
    end
    bus.i_tbl_wr_block = 1'b0;

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 60) rand_upd();
      else bus.i_upd_valid = 1'b0;
      bus.i_tbl_wr_block = ($urandom_range(0, 99) < 30);
      bus.i_flush_req    = ($urandom_range(0, 1999) == 0);
      step();
    end
    bus.i_upd_valid = 1'b0;
    bus.i_flush_req = 1'b0;
    bus.i_tbl_wr_block = 1'b0;
    run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
